control_pc: RTL

- Next-PC controller for the 5-stage MIPS pipeline. Owns the PC register and selects among sequential PC+4, J/JAL target, JR target and EX-resolved branch target.
- Generates the IF/ID and ID/EX flush strobes that squash wrong-path instructions.
- Honours hazard-unit stalls.
- Keeps a sticky JR-misalignment flag and a saturating count of taken redirects for debug.

---
 rtl/control_pc_if.sv | 37 +++
 rtl/control_pc.sv | 104 ++++++++++
 2 files changed

// File: rtl/control_pc_if.sv
// Request/response bundle between the ID/EX pipeline stages and the next-PC controller.
// The master drives redirect and stall requests; the slave owns the PC and the flush strobes.
interface control_pc_if #(
   parameter int ANCHO_CONT = 16
);
   logic                  stall;
   logic                  jump;
   logic [25:0]           instr_index;
   logic [3:0]            pc4_id;
   logic                  jr;
   logic [31:0]           jr_target;
   logic                  branch_taken;
   logic [31:0]           branch_target;
   logic [31:0]           pc;
   logic [31:0]           pc4;
   logic                  flush_if;
   logic                  flush_id;
   logic                  err_alineacion;
   logic [ANCHO_CONT-1:0] redirects;
   logic                  dbg_state;

   // Requests are level signals sampled every CORRE cycle; there is no
   // valid/ready pairing. A request is consumed at the rising edge that ends
   // the cycle in which it is high, unless a higher-priority request masks it.
   // A masked request must be re-presented by the master.
   modport master (
      output stall, jump, instr_index, pc4_id, jr, jr_target,
             branch_taken, branch_target,
      input  pc, pc4, flush_if, flush_id, err_alineacion, redirects, dbg_state
   );

   modport slave (
      input  stall, jump, instr_index, pc4_id, jr, jr_target,
             branch_taken, branch_target,
      output pc, pc4, flush_if, flush_id, err_alineacion, redirects, dbg_state
   );
endinterface

// File: rtl/control_pc.sv
// Next-PC controller: owns the PC, arbitrates branch/stall/JR/J redirects,
// drives the IF/ID and ID/EX flush strobes and keeps debug error/redirect counters.
module control_pc #(
   parameter logic [31:0] PC_RESET   = 32'h0000_0000,
   parameter int          ANCHO_CONT = 16
) (
   input  logic         clk,
   input  logic         reset,
   control_pc_if.slave  bus
);

   typedef enum logic {
      ARRANQUE = 1'b0,
      CORRE    = 1'b1
   } estado_t;

   estado_t               r_estado;
   estado_t               w_estado_sig;
   logic [31:0]           r_pc;
   logic [31:0]           w_pc_sig;
   logic [31:0]           w_pc4;
   logic                  w_flush_if;
   logic                  w_flush_id;
   logic                  w_redirect;
   logic                  w_err_set;
   logic                  r_err;
   logic [ANCHO_CONT-1:0] r_redirects;

   assign w_pc4 = r_pc + 32'd4;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_estado <= ARRANQUE;
         r_pc     <= PC_RESET;
      end else begin
         r_estado <= w_estado_sig;
         r_pc     <= w_pc_sig;
      end
   end

   // Priority: branch squashes everything younger, then stall, then JR, then J.
   always_comb begin
      w_estado_sig = r_estado;
      w_pc_sig     = r_pc;
      w_flush_if   = 1'b1;
      w_flush_id   = 1'b1;
      w_redirect   = 1'b0;
      w_err_set    = 1'b0;
      case (r_estado)
         ARRANQUE: begin
            w_estado_sig = CORRE;
         end
         CORRE: begin
            w_flush_if = 1'b0;
            w_flush_id = 1'b0;
            if (bus.branch_taken) begin
               w_pc_sig   = bus.branch_target;
               w_flush_if = 1'b1;
               w_flush_id = 1'b1;
               w_redirect = 1'b1;
            end else if (bus.stall) begin
               w_flush_id = 1'b1;
            end else if (bus.jr) begin
               w_pc_sig   = {bus.jr_target[31:2], 2'b00};
               w_flush_if = 1'b1;
               w_redirect = 1'b1;
               w_err_set  = (bus.jr_target[1:0] != 2'b00);
            end else if (bus.jump) begin
               w_pc_sig   = {bus.pc4_id, bus.instr_index, 2'b00};
               w_flush_if = 1'b1;
               w_redirect = 1'b1;
            end else begin
               w_pc_sig = w_pc4;
            end
         end
         default: begin
            w_estado_sig = ARRANQUE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err       <= 1'b0;
         r_redirects <= '0;
      end else begin
         if (w_err_set) begin
            r_err <= 1'b1;
         end
         if (w_redirect && (r_redirects != {ANCHO_CONT{1'b1}})) begin
            r_redirects <= r_redirects + 1'b1;
         end
      end
   end

   assign bus.pc             = r_pc;
   assign bus.pc4            = w_pc4;
   assign bus.flush_if       = w_flush_if;
   assign bus.flush_id       = w_flush_id;
   assign bus.err_alineacion = r_err;
   assign bus.redirects      = r_redirects;
   assign bus.dbg_state      = r_estado;

endmodule
